// File: rtl/inst_fetch_stage.sv
// -----------------------------------------------------------------------------
// inst_fetch_stage
//
// Instruction fetch stage of the RV32I 5-stage pipeline. Owns the fetch PC
// (pc_if) and a synchronous-read instruction RAM, and hands the inst_id/pc_id
// pair to decode. Handles EX-stage jump redirection, pipeline flush
// (rst_pipe), run/halt control (cpu_run) and stall hold. This includes replay
// of the instruction held in ID across a stall.
//
// Parameters
//   IWIDTH    instruction RAM address width in 32-bit words
//   NOP_INST  encoding presented on inst_id when no valid instruction exists
//
// Ports
//   clk               clock
//   rst_n             asynchronous active-low reset
//   cpu_run           1 = fetch enabled, 0 = halted (PC parked at start_adr)
//   start_adr[29:0]   word PC ([31:2]) used on run start and rst_pipe
//   jmp_condition_ex  taken jump/branch resolved in EX
//   jmp_adr_ex[29:0]  word PC of the jump target
//   stall             pipeline stall, IF and ID registers hold
//   rst_pipe          synchronous pipeline flush
//   inst_id[31:0]     instruction to ID
//   pc_id[29:0]       word PC of inst_id
//   jmp_purge_if      high for the cycle after a taken jump
//
// Optional feature (macro IMEM_LOAD_PORT_EN)
//   Adds i_ram_wadr / i_ram_wdata / i_ram_wen, a debug-loader write port that
//   is accepted regardless of cpu_run. A write colliding with the read of the
//   same word returns the old contents (read-before-write). Without the macro
//   the RAM has no external write path. Its contents come from FPGA
//   initialisation, or from a simulation preload of the mem array.
// -----------------------------------------------------------------------------
module inst_fetch_stage #(
   parameter int          IWIDTH   = 12,
   parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              cpu_run,
   input  logic [29:0]       start_adr,
   input  logic              jmp_condition_ex,
   input  logic [29:0]       jmp_adr_ex,
   input  logic              stall,
   input  logic              rst_pipe,
`ifdef IMEM_LOAD_PORT_EN
   input  logic [IWIDTH-1:0] i_ram_wadr,
   input  logic [31:0]       i_ram_wdata,
   input  logic              i_ram_wen,
`endif
   output logic [31:0]       inst_id,
   output logic [29:0]       pc_id,
   output logic              jmp_purge_if
);

   localparam int DEPTH = 1 << IWIDTH;

   // ---------------------------------------------------------------------
   // Instruction RAM: one write port (idle unless the load port exists)
   // and one registered read port addressed by pc_if.
   // ---------------------------------------------------------------------
   logic [31:0]       mem [0:DEPTH-1];
   logic [31:0]       ram_rdata;
   logic [IWIDTH-1:0] ram_radr;
   logic [IWIDTH-1:0] ram_wadr;
   logic [31:0]       ram_wdata;
   logic              ram_wen;

`ifdef IMEM_LOAD_PORT_EN
   assign ram_wadr  = i_ram_wadr;
   assign ram_wdata = i_ram_wdata;
   assign ram_wen   = i_ram_wen;
`else
   assign ram_wadr  = '0;
   assign ram_wdata = '0;
   assign ram_wen   = 1'b0;
`endif

   logic [29:0] pc_if;

   assign ram_radr = pc_if[IWIDTH-1:0];

   // The read samples the array before this edge's write lands, so a
   // same-address collision returns the old word.
   always_ff @(posedge clk) begin
      if (ram_wen) begin
         mem[ram_wadr] <= ram_wdata;
      end
      ram_rdata <= mem[ram_radr];
   end

   // ---------------------------------------------------------------------
   // Fetch / ID pipeline registers
   // ---------------------------------------------------------------------
   logic        valid_id;
   logic        stall_dly;
   logic [31:0] inst_roll;

   logic [29:0] pc_if_next;
   logic [29:0] pc_id_next;
   logic        valid_id_next;
   logic        jmp_purge_next;
   logic        stall_dly_next;
   logic [31:0] inst_roll_next;
   logic        stall_1shot;

   assign stall_1shot = stall & ~stall_dly;

   // During a stall the RAM keeps reading pc_if, so ram_rdata runs one word
   // ahead of the held ID slot. The instruction present when the stall
   // began is captured in inst_roll. It is shown while stall_dly is high,
   // which also covers the first cycle after stall drops.
   assign inst_id = stall_dly ? inst_roll : (valid_id ? ram_rdata : NOP_INST);

   always_comb begin
      pc_if_next     = pc_if;
      pc_id_next     = pc_id;
      valid_id_next  = valid_id;
      jmp_purge_next = 1'b0;

      if (rst_pipe || !cpu_run) begin
         pc_if_next    = start_adr;
         pc_id_next    = '0;
         valid_id_next = 1'b0;
      end else if (jmp_condition_ex) begin
         // The word fetched this cycle is on the wrong path. It still moves
         // into ID, but marked invalid so ID sees NOP_INST.
         pc_if_next     = jmp_adr_ex;
         pc_id_next     = pc_if;
         valid_id_next  = 1'b0;
         jmp_purge_next = 1'b1;
      end else if (!stall) begin
         pc_if_next    = pc_if + 30'd1;
         pc_id_next    = pc_if;
         valid_id_next = 1'b1;
      end

      stall_dly_next = rst_pipe ? 1'b0 : stall;
      inst_roll_next = stall_1shot ? inst_id : inst_roll;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc_if        <= '0;
         pc_id        <= '0;
         valid_id     <= 1'b0;
         stall_dly    <= 1'b0;
         inst_roll    <= NOP_INST;
         jmp_purge_if <= 1'b0;
      end else begin
         pc_if        <= pc_if_next;
         pc_id        <= pc_id_next;
         valid_id     <= valid_id_next;
         stall_dly    <= stall_dly_next;
         inst_roll    <= inst_roll_next;
         jmp_purge_if <= jmp_purge_next;
      end
   end

endmodule

// File: tb/tb_inst_fetch_stage.sv
// -----------------------------------------------------------------------------
// tb_inst_fetch_stage
//
// Self-checking bench for inst_fetch_stage. Each cycle the bench drives the
// control inputs and pushes the outputs it expects after the coming clock
// edge onto a scoreboard queue. After the edge it pops that entry and compares
// it with pc_id / inst_id / jmp_purge_if. RAM words follow a simple address
// pattern (mw) that is preloaded into the DUT array at time zero.
// -----------------------------------------------------------------------------
module tb_inst_fetch_stage;

   localparam logic [31:0] NOP = 32'h0000_0013;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        cpu_run = 1'b0;
   logic [29:0] start_adr = '0;
   logic        jmp_condition_ex = 1'b0;
   logic [29:0] jmp_adr_ex = '0;
   logic        stall = 1'b0;
   logic        rst_pipe = 1'b0;
   logic [31:0] inst_id;
   logic [29:0] pc_id;
   logic        jmp_purge_if;
`ifdef IMEM_LOAD_PORT_EN
   logic [11:0] i_ram_wadr = '0;
   logic [31:0] i_ram_wdata = '0;
   logic        i_ram_wen = 1'b0;
`endif

   int err_cnt = 0;
   int chk_cnt = 0;
   int cyc_no  = 0;

   typedef struct {
      int          id;
      bit          chk_pc;
      logic [29:0] pc;
      bit          chk_inst;
      logic [31:0] inst;
      logic        purge;
   } exp_t;

   exp_t exp_q[$];

   inst_fetch_stage #(
      .IWIDTH  (12),
      .NOP_INST(NOP)
   ) dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .cpu_run         (cpu_run),
      .start_adr       (start_adr),
      .jmp_condition_ex(jmp_condition_ex),
      .jmp_adr_ex      (jmp_adr_ex),
      .stall           (stall),
      .rst_pipe        (rst_pipe),
`ifdef IMEM_LOAD_PORT_EN
      .i_ram_wadr      (i_ram_wadr),
      .i_ram_wdata     (i_ram_wdata),
      .i_ram_wen       (i_ram_wen),
`endif
      .inst_id         (inst_id),
      .pc_id           (pc_id),
      .jmp_purge_if    (jmp_purge_if)
   );

   always #5 clk = ~clk;

   // RAM content pattern: unique per word, never equal to NOP.
   function automatic logic [31:0] mw(input logic [29:0] a);
      return {8'hB0, a[11:0], 12'h5A5};
   endfunction

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      chk_cnt++;
      if (obs !== expv) begin
         err_cnt++;
         $display("FAIL %s: got %h, expected %h", tag, obs, expv);
      end
   endtask

   // One clock: drive inputs, push expectation, clock, pop and compare.
   task automatic cyc(input logic run, input logic rp, input logic st, input logic jc,
                      input logic [29:0] ja, input bit cp, input logic [29:0] epc,
                      input bit ci, input logic [31:0] einst, input logic epurge);
      exp_t e;
      cpu_run          = run;
      rst_pipe         = rp;
      stall            = st;
      jmp_condition_ex = jc;
      jmp_adr_ex       = ja;
      cyc_no++;
      e.id = cyc_no; e.chk_pc = cp; e.pc = epc; e.chk_inst = ci; e.inst = einst; e.purge = epurge;
      exp_q.push_back(e);
      @(posedge clk);
      #1;
      e = exp_q.pop_front();
      $display("cyc %0d run=%b rp=%b st=%b jc=%b -> pc_id=%h inst_id=%h purge=%b",
               e.id, run, rp, st, jc, pc_id, inst_id, jmp_purge_if);
      if (e.chk_pc)   check_val($sformatf("c%0d_pc_id", e.id), {2'b00, pc_id}, {2'b00, e.pc});
      if (e.chk_inst) check_val($sformatf("c%0d_inst_id", e.id), inst_id, e.inst);
      check_val($sformatf("c%0d_purge", e.id), {31'd0, jmp_purge_if}, {31'd0, e.purge});
   endtask

   // Expect a valid instruction fetched from word pc.
   task automatic cyc_v(input logic run, input logic rp, input logic st, input logic jc,
                        input logic [29:0] ja, input logic [29:0] pc);
      cyc(run, rp, st, jc, ja, 1'b1, pc, 1'b1, mw(pc), 1'b0);
   endtask

   // Expect NOP on inst_id with the given pc_id and purge flag.
   task automatic cyc_n(input logic run, input logic rp, input logic st, input logic jc,
                        input logic [29:0] ja, input logic [29:0] pc, input logic purge);
      cyc(run, rp, st, jc, ja, 1'b1, pc, 1'b1, NOP, purge);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      for (int i = 0; i < 4096; i++) begin
         dut.mem[i] = mw(30'(i));
      end

      // Reset state
      start_adr = 30'h10;
      repeat (3) @(posedge clk);
      #1;
      check_val("rst_inst_id", inst_id, NOP);
      check_val("rst_pc_id", {2'b00, pc_id}, 32'd0);
      check_val("rst_purge", {31'd0, jmp_purge_if}, 32'd0);
      rst_n = 1'b1;

      // Start-up from start_adr = 0x10
      cyc_n(0, 0, 0, 0, 0, 30'h0, 1'b0);
      cyc_v(1, 0, 0, 0, 0, 30'h10);
      cyc_v(1, 0, 0, 0, 0, 30'h11);
      cyc_v(1, 0, 0, 0, 0, 30'h12);

      // Three-cycle stall with 0x12 in ID, then 0x13 with no gap/duplicate
      repeat (3) cyc_v(1, 0, 1, 0, 0, 30'h12);
      cyc_v(1, 0, 0, 0, 0, 30'h13);
      cyc_v(1, 0, 0, 0, 0, 30'h14);

      // Jump to 0x80 while pc_if = 0x15
      cyc_n(1, 0, 0, 1, 30'h80, 30'h15, 1'b1);
      cyc_v(1, 0, 0, 0, 0, 30'h80);
      cyc_v(1, 0, 0, 0, 0, 30'h81);

      // Jump coincident with stall (pc_if = 0x82)
      cyc(1, 0, 1, 1, 30'h80, 1'b1, 30'h82, 1'b0, 32'h0, 1'b1);
      cyc_v(1, 0, 0, 0, 0, 30'h80);
      cyc_v(1, 0, 0, 0, 0, 30'h81);

      // rst_pipe pulse mid-run, restart at 0
      start_adr = 30'h0;
      cyc_n(1, 1, 0, 0, 0, 30'h0, 1'b0);
      cyc_v(1, 0, 0, 0, 0, 30'h0);
      cyc_v(1, 0, 0, 0, 0, 30'h1);

      // rst_pipe during a stall: no residual replay
      cyc_v(1, 0, 1, 0, 0, 30'h1);
      cyc_n(1, 1, 1, 0, 0, 30'h0, 1'b0);
      cyc_v(1, 0, 0, 0, 0, 30'h0);
      cyc_v(1, 0, 0, 0, 0, 30'h1);

      // 30-bit PC wrap
      start_adr = 30'h3FFF_FFFF;
      cyc_n(1, 1, 0, 0, 0, 30'h0, 1'b0);
      cyc_v(1, 0, 0, 0, 0, 30'h3FFF_FFFF);
      cyc_v(1, 0, 0, 0, 0, 30'h0);

      // Halt has priority over a jump; resume from start_adr
      start_adr = 30'h20;
      cyc_n(0, 0, 0, 0, 0, 30'h0, 1'b0);
      cyc_n(0, 0, 0, 1, 30'h80, 30'h0, 1'b0);
      cyc_v(1, 0, 0, 0, 0, 30'h20);

      // Single-cycle stall
      cyc_v(1, 0, 1, 0, 0, 30'h20);
      cyc_v(1, 0, 0, 0, 0, 30'h21);
      cyc_v(1, 0, 0, 0, 0, 30'h22);

      // Asynchronous reset while a jump and a stall are in flight
      cyc(1, 0, 1, 1, 30'h40, 1'b1, 30'h23, 1'b0, 32'h0, 1'b1);
      rst_n = 1'b0;
      #2;
      check_val("arst_inst_id", inst_id, NOP);
      check_val("arst_pc_id", {2'b00, pc_id}, 32'd0);
      check_val("arst_purge", {31'd0, jmp_purge_if}, 32'd0);
      stall = 1'b0;
      jmp_condition_ex = 1'b0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      start_adr = 30'h30;
      cyc_n(0, 0, 0, 0, 0, 30'h0, 1'b0);
      cyc_v(1, 0, 0, 0, 0, 30'h30);
      cyc_v(1, 0, 0, 0, 0, 30'h31);

`ifdef IMEM_LOAD_PORT_EN
      // Program load while halted, then run from word 5
      start_adr   = 30'h5;
      i_ram_wen   = 1'b1;
      i_ram_wadr  = 12'h005;
      i_ram_wdata = 32'hDEAD_BEEF;
      cyc_n(0, 0, 0, 0, 0, 30'h0, 1'b0);
      i_ram_wadr  = 12'h006;
      i_ram_wdata = 32'h0000_0013;
      cyc_n(0, 0, 0, 0, 0, 30'h0, 1'b0);
      // Write to the word being read this cycle: old data comes back
      i_ram_wadr  = 12'h005;
      i_ram_wdata = 32'hCAFE_F00D;
      cyc(1, 0, 0, 0, 0, 1'b1, 30'h5, 1'b1, 32'hDEAD_BEEF, 1'b0);
      i_ram_wen   = 1'b0;
      cyc(1, 0, 0, 0, 0, 1'b1, 30'h6, 1'b1, 32'h0000_0013, 1'b0);
      cyc_n(0, 0, 0, 0, 0, 30'h0, 1'b0);
      cyc(1, 0, 0, 0, 0, 1'b1, 30'h5, 1'b1, 32'hCAFE_F00D, 1'b0);
`endif

      $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
      $finish;
   end

endmodule
